// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (receiver and transmitter side).
package serial_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Parity bit a transmitter appends to data (zero-extended to 16 bits).
  function automatic logic parity_bit(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Output-side bundle of serial_receiver: word handshake, error pulses, busy.
interface serial_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/serial_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module serial_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Double-register the input; both stages reset to the idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/serial_receiver.sv
// Oversampling serial frame receiver with one-entry valid/ready output slot.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic serial_in,
  serial_receiver_if.master rx
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  logic                 line;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitn;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 mid_bit;
  logic                 stop_sample;

  serial_sync #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (serial_in),
    .q       (line)
  );

  assign mid_bit     = (cnt == CNT_FULL);
  assign stop_sample = (state == RX_STOP) && mid_bit;
  assign rx.busy     = (state != RX_IDLE);

  // Frame FSM: bit timing counters, LSB-first shift register, parity latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bitn    <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (line == START_BIT) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bitn    <= '0;
            par_bad <= 1'b0;
            state   <= (line == START_BIT) ? RX_DATA : RX_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (mid_bit) begin
            cnt   <= '0;
            shreg <= {line, shreg[DATA_BITS-1:1]};
            if (bitn == BIT_LAST) state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            else                  bitn  <= bitn + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (mid_bit) begin
            cnt     <= '0;
            par_bad <= (line != parity_bit(16'(shreg), ODD));
            state   <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (mid_bit) begin
            cnt   <= '0;
            state <= (line == STOP_BIT) ? RX_IDLE : RX_WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_WAIT_IDLE: begin
          if (line == IDLE_LEVEL) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Output slot and error pulses; completion is decided on the stop-bit sample edge,
  // so a same-cycle consume frees the slot for the new word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx.rx_data    <= '0;
      rx.rx_valid   <= 1'b0;
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.overrun    <= 1'b0;
    end else begin
      rx.frame_err  <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.overrun    <= 1'b0;
      if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
      if (stop_sample) begin
        if (line != STOP_BIT) begin
          rx.frame_err <= 1'b1;
        end else if (par_bad) begin
          rx.parity_err <= 1'b1;
        end else if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data  <= shreg;
          rx.rx_valid <= 1'b1;
        end else begin
          rx.overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_receiver.sv
// Directed plus randomized bench for serial_receiver (no-parity and even-parity instances).
module tb_serial_receiver;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s0 = 1'b1;
  logic s1 = 1'b1;
  int   cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_receiver_if #(.DATA_BITS(8)) bus0 ();
  serial_receiver_if #(.DATA_BITS(8)) bus1 ();

  serial_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset_n(reset_n), .serial_in(s0), .rx(bus0));
  serial_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset_n(reset_n), .serial_in(s1), .rx(bus1));

  // Monitor: words accepted by the consumer, error pulse counts, rx_valid rise cycles.
  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int rises0[$];
  int ferr0 = 0, perr0 = 0, ovr0 = 0, ferr1 = 0, perr1 = 0, ovr1 = 0;
  logic pv0 = 1'b0;
  always @(negedge clk) begin
    if (bus0.rx_valid && bus0.rx_ready) got0.push_back(bus0.rx_data);
    if (bus1.rx_valid && bus1.rx_ready) got1.push_back(bus1.rx_data);
    if (bus0.frame_err)  ferr0++;
    if (bus0.parity_err) perr0++;
    if (bus0.overrun)    ovr0++;
    if (bus1.frame_err)  ferr1++;
    if (bus1.parity_err) perr1++;
    if (bus1.overrun)    ovr1++;
    if (bus0.rx_valid && !pv0) rises0.push_back(cyc);
    pv0 = bus0.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input int which, input logic b, input int n);
    if (which == 0) s0 = b; else s1 = b;
    idle(n);
  endtask

  // One frame: start, 8 data LSB-first, optional parity, one stop bit; 16 clk per bit.
  task automatic send_frame(input int which, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop);
    drive(which, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(which, d[i], 16);
    if (with_par) drive(which, par, 16);
    drive(which, stop, 16);
  endtask

  function automatic logic [31:0] pop0();
    return (got0.size() > 0) ? 32'(got0.pop_front()) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] pop1();
    return (got1.size() > 0) ? 32'(got1.pop_front()) : 32'hDEAD;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp0[$];
    logic [7:0] exp1[$];
    logic [7:0] d;
    int fall, lat, nr, f0, p0, o0, p1, nbad, n;
    bit good;

    bus0.rx_ready = 1'b1;
    bus1.rx_ready = 1'b1;
    idle(3);
    // Reset values
    check("rst_valid", 32'(bus0.rx_valid), 0);
    check("rst_data", 32'(bus0.rx_data), 0);
    check("rst_busy", 32'(bus0.busy), 0);
    check("rst_flags", {29'd0, bus0.frame_err, bus0.parity_err, bus0.overrun}, 0);
    check("rst_busy_p", 32'(bus1.busy), 0);
    reset_n = 1'b1;
    idle(5);
    check("post_rst_busy", 32'(bus0.busy), 0);

    // 1: single word, latency from falling edge to rx_valid rise
    nr = rises0.size();
    fall = cyc;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
    idle(4);
    check("t1_count", 32'(got0.size()), 1);
    check("t1_data", pop0(), 32'hA5);
    lat = (rises0.size() > nr) ? rises0[nr] - fall : -1;
    n_cmp++;
    assert (lat >= 153 && lat <= 155) else begin
      n_fail++;
      $error("FAIL t1_latency: observed %0d expected 154+/-1", lat);
    end
    check("t1_flags", 32'(ferr0 + perr0 + ovr0), 0);

    // 2: back-to-back with consumer stalled -> overrun, first word kept
    bus0.rx_ready = 1'b0;
    o0 = ovr0;
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    send_frame(0, 8'hC3, 0, 1'b0, 1'b1);
    idle(4);
    check("t2_valid", 32'(bus0.rx_valid), 1);
    check("t2_data", 32'(bus0.rx_data), 32'h3C);
    check("t2_overrun", 32'(ovr0 - o0), 1);
    bus0.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_drop", 32'(bus0.rx_valid), 0);
    #1;
    check("t2_taken", pop0(), 32'h3C);
    check("t2_rest", 32'(got0.size()), 0);

    // 3: 5-clk glitch on the line
    f0 = ferr0; p0 = perr0; o0 = ovr0;
    drive(0, 1'b0, 4);
    check("t3_busy_hi", 32'(bus0.busy), 1);
    drive(0, 1'b0, 1);
    drive(0, 1'b1, 20);
    check("t3_busy_lo", 32'(bus0.busy), 0);
    check("t3_valid", 32'(bus0.rx_valid), 0);
    check("t3_flags", 32'((ferr0 - f0) + (perr0 - p0) + (ovr0 - o0)), 0);

    // 4: bad stop bit then held-low break -> exactly one frame_err
    f0 = ferr0;
    send_frame(0, 8'h55, 0, 1'b0, 1'b0);
    drive(0, 1'b0, 40);
    drive(0, 1'b1, 20);
    check("t4_ferr", 32'(ferr0 - f0), 1);
    check("t4_valid", 32'(bus0.rx_valid), 0);
    check("t4_none", 32'(got0.size()), 0);
    send_frame(0, 8'h0F, 0, 1'b0, 1'b1);
    idle(4);
    check("t4_next", pop0(), 32'h0F);

    // 5: even parity instance, good then bad parity bit
    p1 = perr1;
    send_frame(1, 8'h07, 1, 1'b1, 1'b1);
    idle(4);
    check("t5_good", pop1(), 32'h07);
    send_frame(1, 8'h07, 1, 1'b0, 1'b1);
    idle(4);
    check("t5_perr", 32'(perr1 - p1), 1);
    check("t5_novalid", 32'(bus1.rx_valid), 0);
    check("t5_none", 32'(got1.size()), 0);

    // 6: reset in data bit 4 while a word is held in the slot
    bus0.rx_ready = 1'b0;
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
    idle(2);
    check("t6_held", 32'(bus0.rx_valid), 1);
    f0 = ferr0; p0 = perr0; o0 = ovr0;
    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 16);
    drive(0, 1'b1, 8);
    reset_n = 1'b0;
    #1;
    check("t6_valid", 32'(bus0.rx_valid), 0);
    check("t6_data", 32'(bus0.rx_data), 0);
    check("t6_busy", 32'(bus0.busy), 0);
    #1;
    s0 = 1'b1;
    idle(3);
    reset_n = 1'b1;
    bus0.rx_ready = 1'b1;
    idle(40);
    check("t6_quiet", 32'((ferr0 - f0) + (perr0 - p0) + (ovr0 - o0)), 0);
    check("t6_idle_valid", 32'(bus0.rx_valid), 0);
    send_frame(0, 8'h81, 0, 1'b0, 1'b1);
    idle(4);
    check("t6_data81", pop0(), 32'h81);
    check("t6_flags", 32'((ferr0 - f0) + (perr0 - p0) + (ovr0 - o0)), 0);

    // Random words, random gaps (including none), consumer always ready
    f0 = ferr0; p0 = perr0; o0 = ovr0;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom_range(0, 255));
      exp0.push_back(d);
      send_frame(0, d, 0, 1'b0, 1'b1);
      n = int'($urandom_range(0, 12));
      if (n > 0) idle(n);
    end
    idle(10);
    check("rnd0_count", 32'(got0.size()), 32'(exp0.size()));
    while (exp0.size() > 0) check("rnd0_data", pop0(), 32'(exp0.pop_front()));
    check("rnd0_flags", 32'((ferr0 - f0) + (perr0 - p0) + (ovr0 - o0)), 0);

    // Random words with randomly corrupted parity on the parity instance
    p1 = perr1;
    nbad = 0;
    for (int k = 0; k < 12; k++) begin
      d = 8'($urandom_range(0, 255));
      good = bit'($urandom_range(0, 1));
      if (good) exp1.push_back(d); else nbad++;
      send_frame(1, d, 1, good ? (^d) : ~(^d), 1'b1);
      n = int'($urandom_range(0, 6));
      if (n > 0) idle(n);
    end
    idle(10);
    check("rnd1_perr", 32'(perr1 - p1), 32'(nbad));
    check("rnd1_count", 32'(got1.size()), 32'(exp1.size()));
    while (exp1.size() > 0) check("rnd1_data", pop1(), 32'(exp1.pop_front()));
    check("rnd1_other", 32'(ferr1 + ovr1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
